// File: rtl/exception_resolver_pkg.sv
// Shared CPU definitions for the MEM-stage exception resolver: pipeline exception
// flags, register write enables, ExcCodes, redirect kinds and CP0 addresses.
package exception_resolver_pkg;

  typedef struct packed {
    logic ri;
    logic sys;
    logic bp;
    logic ov;
    logic rd_wrong_addr;
    logic wr_wrong_addr;
    logic eret;
  } ExceptinPipeType;

  typedef struct packed {
    logic rf;
    logic hi;
    logic lo;
  } RegsWrType;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [1:0] IsNone      = 2'd0;
  localparam logic [1:0] IsException = 2'd1;
  localparam logic [1:0] IsEret      = 2'd2;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Only the software interrupt bits and IV/WP are writable in Cause.
  localparam logic [31:0] CAUSE_FWD_MASK = 32'h00C0_0300;

endpackage

// File: rtl/exception_resolver_if.sv
// Redirect handshake between the exception resolver (master) and instruction fetch (slave).
interface exception_resolver_if;

  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc;
  logic        redir_ready;

  modport master (
    output redir_valid,
    output redir_kind,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_kind,
    input  redir_pc,
    output redir_ready
  );

endinterface

// File: rtl/exception_resolver_int_sampler.sv
// Registers the asynchronous hardware interrupt lines. With INT_SYNC_EN defined a
// 2-flop synchroniser precedes the sample flop (3 cycles latency), otherwise 1 cycle.
module exception_resolver_int_sampler
  import exception_resolver_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sampled
);

`ifdef INT_SYNC_EN
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      sampled <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      sampled <= sync_q2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      sampled <= '0;
    end else begin
      sampled <= raw;
    end
  end
`endif

endmodule

// File: rtl/exception_resolver.sv
// MEM-stage precise-exception resolver: prioritises exceptions, commits to CP0 and
// issues a held PC redirect to IF. Optional macro INT_SYNC_EN adds an interrupt synchroniser.
module exception_resolver
  import exception_resolver_pkg::*;
#(
  parameter int NUM_HW_INT = 6,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid_i,
  input  logic                  mem_stall_i,
  input  logic [ADDR_W-1:0]     mem_pc_i,
  input  logic                  mem_in_ds_i,
  input  logic [ADDR_W-1:0]     mem_vaddr_i,
  input  ExceptinPipeType       exc_i,
  input  RegsWrType             regs_wr_i,
  output RegsWrType             regs_wr_o,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic [31:0]           cp0_status_i,
  input  logic [31:0]           cp0_cause_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic                  wb_cp0_we_i,
  input  logic [4:0]            wb_cp0_addr_i,
  input  logic [31:0]           wb_cp0_wdata_i,
  output logic                  ifid_flush_o,
  output logic                  idexe_flush_o,
  output logic                  exemem_flush_o,
  output logic                  cp0_exc_we_o,
  output logic [4:0]            cp0_exc_code_o,
  output logic [31:0]           cp0_epc_o,
  output logic                  cp0_bd_o,
  output logic                  cp0_badva_we_o,
  output logic [31:0]           cp0_badva_o,
  exception_resolver_if.master  redir
);

  localparam int NUM_PEND = NUM_HW_INT + 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic {
    IDLE,
    REDIR
  } state_t;

  state_t state;

  logic [NUM_HW_INT-1:0] hw_int_sampled;
  logic [31:0]           status_fwd;
  logic [31:0]           cause_fwd;
  logic [31:0]           epc_fwd;
  logic [NUM_PEND-1:0]   pending;
  logic                  int_req;
  logic                  pc_misaligned;
  logic                  exc_hit;
  logic                  take;
  logic                  commit;
  logic                  is_eret;
  logic [4:0]            code;
  logic                  badva_we;
  logic [31:0]           badva;
  logic [31:0]           epc_calc;
  logic                  unused_cp0_bits;

  exception_resolver_int_sampler #(
    .WIDTH (NUM_HW_INT)
  ) u_int_sampler (
    .clk     (clk),
    .rst     (rst),
    .raw     (hw_int_i),
    .sampled (hw_int_sampled)
  );

  // A CP0 write sitting in WB this cycle is not yet visible on the CP0 outputs.
  always_comb begin
    status_fwd = cp0_status_i;
    cause_fwd  = cp0_cause_i;
    epc_fwd    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_addr_i)
        CP0_STATUS: status_fwd = wb_cp0_wdata_i;
        CP0_CAUSE:  cause_fwd  = wb_cp0_wdata_i & CAUSE_FWD_MASK;
        CP0_EPC:    epc_fwd    = wb_cp0_wdata_i;
        default:    ;
      endcase
    end
  end

  assign unused_cp0_bits = ^{status_fwd, cause_fwd};

  assign pending       = {hw_int_sampled, cause_fwd[9:8]};
  assign int_req       = (|(pending & status_fwd[8 +: NUM_PEND])) && !status_fwd[1] && status_fwd[0];
  assign pc_misaligned = |mem_pc_i[1:0];
  assign exc_hit       = pc_misaligned || (|exc_i);
  assign take          = !rst && mem_valid_i && !mem_stall_i && (state == IDLE) && (int_req || exc_hit);
  assign epc_calc      = 32'(mem_in_ds_i ? mem_pc_i - PC_STEP : mem_pc_i);

  always_comb begin
    commit   = 1'b1;
    is_eret  = 1'b0;
    code     = EXC_INT;
    badva_we = 1'b0;
    badva    = '0;
    if (int_req) begin
      code = EXC_INT;
    end else if (pc_misaligned) begin
      code     = EXC_ADEL;
      badva_we = 1'b1;
      badva    = 32'(mem_pc_i);
    end else if (exc_i.ri) begin
      code = EXC_RI;
    end else if (exc_i.sys) begin
      code = EXC_SYS;
    end else if (exc_i.bp) begin
      code = EXC_BP;
    end else if (exc_i.ov) begin
      code = EXC_OV;
    end else if (exc_i.rd_wrong_addr) begin
      code     = EXC_ADEL;
      badva_we = 1'b1;
      badva    = 32'(mem_vaddr_i);
    end else if (exc_i.wr_wrong_addr) begin
      code     = EXC_ADES;
      badva_we = 1'b1;
      badva    = 32'(mem_vaddr_i);
    end else begin
      commit  = 1'b0;
      is_eret = exc_i.eret;
    end
  end

  // While a redirect is outstanding, whatever reaches MEM is on the wrong path.
  always_comb begin
    ifid_flush_o   = 1'b0;
    idexe_flush_o  = 1'b0;
    exemem_flush_o = 1'b0;
    regs_wr_o      = regs_wr_i;
    cp0_exc_we_o   = 1'b0;
    cp0_exc_code_o = '0;
    cp0_epc_o      = '0;
    cp0_bd_o       = 1'b0;
    cp0_badva_we_o = 1'b0;
    cp0_badva_o    = '0;
    if (rst) begin
      regs_wr_o = '0;
    end else begin
      if (take || (state == REDIR)) begin
        ifid_flush_o = 1'b1;
        regs_wr_o    = '0;
      end
      if (take) begin
        idexe_flush_o  = 1'b1;
        exemem_flush_o = 1'b1;
        if (commit) begin
          cp0_exc_we_o   = 1'b1;
          cp0_exc_code_o = code;
          cp0_epc_o      = epc_calc;
          cp0_bd_o       = mem_in_ds_i;
          cp0_badva_we_o = badva_we;
          cp0_badva_o    = badva;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      redir.redir_valid <= 1'b0;
      redir.redir_kind  <= IsNone;
      redir.redir_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state             <= REDIR;
            redir.redir_valid <= 1'b1;
            redir.redir_kind  <= is_eret ? IsEret : IsException;
            redir.redir_pc    <= is_eret ? epc_fwd : EXC_VECTOR;
          end
        end
        REDIR: begin
          if (redir.redir_ready) begin
            state             <= IDLE;
            redir.redir_valid <= 1'b0;
            redir.redir_kind  <= IsNone;
            redir.redir_pc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_resolver.sv
// Self-checking bench for exception_resolver: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_exception_resolver;
  import exception_resolver_pkg::*;

  localparam int NHW = 6;
`ifdef INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid, mem_stall, mem_in_ds;
  logic [31:0]     mem_pc, mem_vaddr;
  ExceptinPipeType exc;
  RegsWrType       regs_in, regs_out;
  logic [NHW-1:0]  hw_int;
  logic [31:0]     cp0_status, cp0_cause, cp0_epc;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_wdata;
  logic            ifid_flush, idexe_flush, exemem_flush;
  logic            cp0_we, cp0_bd, badva_we;
  logic [4:0]      cp0_code;
  logic [31:0]     cp0_epc_out, badva;

  exception_resolver_if rif();

  exception_resolver #(.NUM_HW_INT(NHW), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid), .mem_stall_i(mem_stall), .mem_pc_i(mem_pc),
    .mem_in_ds_i(mem_in_ds), .mem_vaddr_i(mem_vaddr), .exc_i(exc),
    .regs_wr_i(regs_in), .regs_wr_o(regs_out), .hw_int_i(hw_int),
    .cp0_status_i(cp0_status), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_addr_i(wb_addr), .wb_cp0_wdata_i(wb_wdata),
    .ifid_flush_o(ifid_flush), .idexe_flush_o(idexe_flush), .exemem_flush_o(exemem_flush),
    .cp0_exc_we_o(cp0_we), .cp0_exc_code_o(cp0_code), .cp0_epc_o(cp0_epc_out),
    .cp0_bd_o(cp0_bd), .cp0_badva_we_o(badva_we), .cp0_badva_o(badva),
    .redir(rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: interrupt history (index 0 = newest posedge) and outstanding redirect
  logic [NHW-1:0] hw_hist [3];
  bit             model_busy;
  logic [1:0]     model_kind;
  logic [31:0]    model_pc;
  bit             model_live = 0;

  typedef struct {
    bit          take;
    bit          ifid, idexe, exemem;
    logic [2:0]  regs;
    bit          we;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    bit          bvwe;
    logic [31:0] bva;
    logic [1:0]  next_kind;
    logic [31:0] next_pc;
  } exp_t;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t modelEval();
    exp_t        e;
    logic [31:0] st, ca, ep;
    logic [NHW-1:0] smp;
    bit          ireq, pbit;
    int          win;
    bit          cond [9];
    int          codes [9];
    int          bsel [9];
    e.take = 0; e.ifid = 0; e.idexe = 0; e.exemem = 0; e.regs = '0; e.we = 0;
    e.code = '0; e.epc = '0; e.bd = 0; e.bvwe = 0; e.bva = '0;
    e.next_kind = 2'd0; e.next_pc = '0;
    st  = (wb_we && wb_addr == 5'd12) ? wb_wdata : cp0_status;
    ca  = (wb_we && wb_addr == 5'd13) ? {8'h0, wb_wdata[23:22], 12'h0, wb_wdata[9:8], 8'h0} : cp0_cause;
    ep  = (wb_we && wb_addr == 5'd14) ? wb_wdata : cp0_epc;
    smp = hw_hist[LAT-1];
    ireq = 0;
    if (st[0] && !st[1]) begin
      for (int i = 0; i < NHW + 2; i++) begin
        if (i < 2) pbit = ca[8+i];
        else       pbit = smp[i-2];
        if (pbit && st[8+i]) ireq = 1;
      end
    end
    cond  = '{ireq, mem_pc[1:0] != 2'b00, exc.ri, exc.sys, exc.bp, exc.ov,
              exc.rd_wrong_addr, exc.wr_wrong_addr, exc.eret};
    codes = '{0, 4, 10, 8, 9, 12, 4, 5, 0};
    bsel  = '{0, 1, 0, 0, 0, 0, 2, 2, 0};
    win = -1;
    for (int i = 0; i < 9; i++) if (cond[i] && win < 0) win = i;
    if (rst) return e;
    e.take   = mem_valid && !mem_stall && !model_busy && (win >= 0);
    e.ifid   = e.take || model_busy;
    e.idexe  = e.take;
    e.exemem = e.take;
    e.regs   = e.ifid ? 3'b000 : regs_in;
    if (e.take && win != 8) begin
      e.we   = 1;
      e.code = 5'(codes[win]);
      e.epc  = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
      e.bd   = mem_in_ds;
      e.bvwe = (bsel[win] != 0);
      e.bva  = (bsel[win] == 1) ? mem_pc : (bsel[win] == 2) ? mem_vaddr : 32'd0;
    end
    e.next_kind = (win == 8) ? 2'd2 : 2'd1;
    e.next_pc   = (win == 8) ? ep : 32'hBFC0_0380;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (!model_live) return;
    e = modelEval();
    checkVal("ifid_flush",   32'(ifid_flush),   32'(e.ifid));
    checkVal("idexe_flush",  32'(idexe_flush),  32'(e.idexe));
    checkVal("exemem_flush", 32'(exemem_flush), 32'(e.exemem));
    checkVal("regs_wr",      32'(regs_out),     32'(e.regs));
    checkVal("cp0_exc_we",   32'(cp0_we),       32'(e.we));
    checkVal("cp0_exc_code", 32'(cp0_code),     32'(e.code));
    checkVal("cp0_epc",      cp0_epc_out,       e.epc);
    checkVal("cp0_bd",       32'(cp0_bd),       32'(e.bd));
    checkVal("badva_we",     32'(badva_we),     32'(e.bvwe));
    checkVal("badva",        badva,             e.bva);
    checkVal("redir_valid",  32'(rif.redir_valid), 32'(model_busy));
    checkVal("redir_kind",   32'(rif.redir_kind),  32'(model_kind));
    checkVal("redir_pc",     rif.redir_pc,         model_pc);
  endtask

  task automatic modelUpdate();
    exp_t e;
    e = modelEval();
    if (rst) begin
      for (int i = 0; i < 3; i++) hw_hist[i] = '0;
      model_busy = 0; model_kind = 2'd0; model_pc = '0;
    end else begin
      if (!model_busy && e.take) begin
        model_busy = 1; model_kind = e.next_kind; model_pc = e.next_pc;
      end else if (model_busy && rif.redir_ready) begin
        model_busy = 0; model_kind = 2'd0; model_pc = '0;
      end
      hw_hist[2] = hw_hist[1];
      hw_hist[1] = hw_hist[0];
      hw_hist[0] = hw_int;
    end
    model_live = 1;
  endtask

  task automatic step();
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic setIdle();
    rst = 0; mem_valid = 0; mem_stall = 0; mem_pc = 32'h8000_0000; mem_in_ds = 0;
    mem_vaddr = '0; exc = '0; regs_in = 3'b111; hw_int = '0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    wb_we = 0; wb_addr = '0; wb_wdata = '0; rif.redir_ready = 0;
  endtask

  task automatic finishRedirect();
    setIdle();
    rif.redir_ready = 1;
    step();
    setIdle();
  endtask

  task automatic applyStimulus();
    rst        = ($urandom_range(0, 99) < 2);
    mem_valid  = ($urandom_range(0, 9) < 8);
    mem_stall  = ($urandom_range(0, 9) < 2);
    mem_pc     = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) mem_pc[1:0] = 2'($urandom_range(1, 3));
    mem_in_ds  = ($urandom_range(0, 3) == 0);
    mem_vaddr  = $urandom;
    exc.ri            = ($urandom_range(0, 19) == 0);
    exc.sys           = ($urandom_range(0, 19) == 0);
    exc.bp            = ($urandom_range(0, 19) == 0);
    exc.ov            = ($urandom_range(0, 19) == 0);
    exc.rd_wrong_addr = ($urandom_range(0, 19) == 0);
    exc.wr_wrong_addr = ($urandom_range(0, 19) == 0);
    exc.eret          = ($urandom_range(0, 14) == 0);
    regs_in    = 3'($urandom);
    if ($urandom_range(0, 7) == 0)
      hw_int = ($urandom_range(0, 2) == 0) ? NHW'(1 << $urandom_range(0, NHW - 1)) : '0;
    cp0_status = {16'h0, 8'($urandom), 6'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0};
    cp0_cause  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FCFF);
    cp0_epc    = $urandom;
    wb_we      = ($urandom_range(0, 4) == 0);
    case ($urandom_range(0, 3))
      0: wb_addr = 5'd12;
      1: wb_addr = 5'd13;
      2: wb_addr = 5'd14;
      default: wb_addr = 5'($urandom);
    endcase
    wb_wdata   = $urandom;
    rif.redir_ready = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    setIdle();
    rst = 1;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);

    // reset state, with regs_wr_i all ones
    #1;
    checkVal("rst_redir_valid", 32'(rif.redir_valid), 0);
    checkVal("rst_redir_kind",  32'(rif.redir_kind), 0);
    checkVal("rst_redir_pc",    rif.redir_pc, 0);
    checkVal("rst_regs_wr",     32'(regs_out), 0);
    checkVal("rst_cp0_we",      32'(cp0_we), 0);
    step();
    setIdle();
    step();

    // Ov at 0x8000_0010
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0010; exc.ov = 1; regs_in = 3'b101;
    #1;
    checkVal("t1_ifid",   32'(ifid_flush), 1);
    checkVal("t1_idexe",  32'(idexe_flush), 1);
    checkVal("t1_exemem", 32'(exemem_flush), 1);
    checkVal("t1_code",   32'(cp0_code), 12);
    checkVal("t1_epc",    cp0_epc_out, 32'h8000_0010);
    checkVal("t1_regs",   32'(regs_out), 0);
    checkVal("t1_valid_T0", 32'(rif.redir_valid), 0);
    step();
    setIdle(); rif.redir_ready = 1;
    #1;
    checkVal("t1_valid_T1", 32'(rif.redir_valid), 1);
    checkVal("t1_pc",       rif.redir_pc, 32'hBFC0_0380);
    checkVal("t1_kind",     32'(rif.redir_kind), 1);
    step();
    setIdle();
    #1;
    checkVal("t1_valid_drop", 32'(rif.redir_valid), 0);
    step();

    // Sys in delay slot
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0024; mem_in_ds = 1; exc.sys = 1;
    #1;
    checkVal("t2_epc",  cp0_epc_out, 32'h8000_0020);
    checkVal("t2_bd",   32'(cp0_bd), 1);
    checkVal("t2_code", 32'(cp0_code), 8);
    step();
    finishRedirect();

    // Eret with EPC forwarded from WB
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0030; exc.eret = 1;
    cp0_epc = 32'h1111_2220; wb_we = 1; wb_addr = 5'd14; wb_wdata = 32'h8000_1000;
    #1;
    checkVal("t3_cp0_we", 32'(cp0_we), 0);
    checkVal("t3_ifid",   32'(ifid_flush), 1);
    step();
    setIdle(); rif.redir_ready = 1;
    #1;
    checkVal("t3_kind", 32'(rif.redir_kind), 2);
    checkVal("t3_pc",   rif.redir_pc, 32'h8000_1000);
    step();
    setIdle();

    // Read address error together with Ov, then alone
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0040; mem_vaddr = 32'h1003;
    exc.rd_wrong_addr = 1; exc.ov = 1;
    #1;
    checkVal("t6_code_ov",   32'(cp0_code), 12);
    checkVal("t6_no_badva",  32'(badva_we), 0);
    step();
    finishRedirect();
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0044; mem_vaddr = 32'h1003; exc.rd_wrong_addr = 1;
    #1;
    checkVal("t6_code_adel", 32'(cp0_code), 4);
    checkVal("t6_badva_we",  32'(badva_we), 1);
    checkVal("t6_badva",     badva, 32'h1003);
    step();
    finishRedirect();

    // Stalled instruction waits for the stall to release
    setIdle(); mem_valid = 1; mem_stall = 1; mem_pc = 32'h8000_0048; exc.bp = 1;
    #1;
    checkVal("stall_no_take", 32'(cp0_we), 0);
    step();
    mem_stall = 0;
    #1;
    checkVal("stall_release_code", 32'(cp0_code), 9);
    step();
    finishRedirect();

    // Hardware interrupt latency
    for (int i = 0; i < LAT; i++) begin
      setIdle(); cp0_status = 32'h0000_0401; hw_int = NHW'(1); mem_valid = 1; mem_pc = 32'h8000_0050;
      #1;
      checkVal("t4_int_not_yet", 32'(cp0_we), 0);
      step();
    end
    setIdle(); cp0_status = 32'h0000_0401; hw_int = NHW'(1); mem_valid = 1; mem_pc = 32'h8000_0050;
    #1;
    checkVal("t4_int_taken", 32'(cp0_we), 1);
    checkVal("t4_int_code",  32'(cp0_code), 0);
    checkVal("t4_int_epc",   cp0_epc_out, 32'h8000_0050);
    step();
    finishRedirect();
    for (int i = 0; i < LAT + 1; i++) begin
      setIdle(); cp0_status = 32'h0000_0403; hw_int = NHW'(1); mem_valid = 1; mem_pc = 32'h8000_0058;
      #1;
      checkVal("t4_exl_blocks", 32'(cp0_we), 0);
      step();
    end
    setIdle(); cp0_status = 32'h0000_0401; hw_int = NHW'(1); mem_valid = 1;
    mem_pc = 32'h8000_0060; exc.sys = 1;
    #1;
    checkVal("int_beats_sys_code", 32'(cp0_code), 0);
    checkVal("int_beats_sys_epc",  cp0_epc_out, 32'h8000_0060);
    step();
    finishRedirect();

    // Redirect held without ready, second exception ignored, reset in cycle 3
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0070; exc.ov = 1;
    step();
    setIdle();
    #1;
    checkVal("t5_c1_valid", 32'(rif.redir_valid), 1);
    checkVal("t5_c1_pc",    rif.redir_pc, 32'hBFC0_0380);
    step();
    setIdle(); mem_valid = 1; mem_pc = 32'h8000_0074; exc.sys = 1; regs_in = 3'b111;
    #1;
    checkVal("t5_c2_kind",     32'(rif.redir_kind), 1);
    checkVal("t5_c2_pc",       rif.redir_pc, 32'hBFC0_0380);
    checkVal("t5_c2_no_take",  32'(cp0_we), 0);
    checkVal("t5_c2_regs",     32'(regs_out), 0);
    step();
    setIdle(); rst = 1;
    #1;
    checkVal("t5_c3_valid", 32'(rif.redir_valid), 1);
    step();
    setIdle();
    #1;
    checkVal("t5_after_rst_valid", 32'(rif.redir_valid), 0);
    checkVal("t5_after_rst_kind",  32'(rif.redir_kind), 0);
    checkVal("t5_after_rst_pc",    rif.redir_pc, 0);
    step();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
